alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Issuing side of the ALU interface. Owns the accumulator (A operand) and the B operand register.
//  Accepts one ALU command per handshake and drives the ALU's in_a, in_b, mode, ee and eo pins.
//  Reads the ALU result back off the shared tristate 8-bit bus and writes it into the accumulator.
//  Publishes clean status flags. Sits between the instruction decoder and the ALU.
// PARAMETERS
//  WIDTH      8      datapath / bus width
//  ACC_RESET  8'h00  accumulator value after reset
// PORTS
//  clk             in     1      system clock; all state updates on posedge
//  rst             in     1      synchronous, active-high reset
//  cmd_valid       in     1      decoder offers a command
//  cmd_ready       out    1      sequencer can accept; high only in IDLE
//  cmd_mode        in     3      ALU op: 000 add, 001 adc, 010 sub, 011 inc, 100 dec, 101 and, 110 or, 111 xor
//  cmd_operand     in     WIDTH  B operand, latched on accept
//  alu_a           out    WIDTH  drives ALU in_a; equals acc
//  alu_b           out    WIDTH  drives ALU in_b; equals latched operand
//  alu_mode        out    3      drives ALU mode
//  alu_ee          out    1      ALU execute enable; one-cycle pulse
//  alu_eo          out    1      ALU bus output enable; one-cycle pulse
//  alu_carry       in     1      ALU carry flag
//  bus             inout  WIDTH  shared tristate data bus
//  acc             out    WIDTH  accumulator
//  flag_zero       out    1      last result == 0
//  flag_carry      out    1      carry/borrow of the last add/adc/sub; 0 after logic ops
//  done            out    1      one-cycle pulse when the write-back has landed
// BEHAVIOUR
//  Reset values (rst high at posedge):
//   - acc = ACC_RESET; alu_b = 0; alu_mode = 0.
//   - flag_zero = 0; flag_carry = 0; done = 0.
//   - alu_ee = 0; alu_eo = 0; state = IDLE.
//  All outputs are registered, so reset mid-operation aborts immediately.
//   - No ee/eo pulse follows reset.
//   - acc is not written by an aborted command.
//  FSM: IDLE -> EXEC -> WAIT -> WB -> IDLE.
//   - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch cmd_mode and cmd_operand, go to EXEC.
//   - EXEC: alu_ee = 1 for exactly this cycle; the ALU registers its result at the closing edge.
//   - WAIT: ee = eo = 0; the ALU result is stable. Go to WB.
//   - WB: alu_eo = 1.
//       - At the closing edge: acc <= bus; flag_zero <= (bus == 0).
//       - flag_carry <= alu_carry for 000/001/010; <= 0 for 101/110/111; unchanged for 011/100.
//       - done <= 1 for the following cycle; return to IDLE.
//  Latency: accept at cycle 0, done high at cycle 4. Back-to-back throughput: one command per 4 cycles.
//  The zero flag is derived locally from the write-back value every command, never taken from the ALU.
//  cmd_valid while busy: ignored (cmd_ready = 0). Inputs need not be held after accept.
//  Bus: the sequencer never drives bus except as set out under CONFIGURATION.
//   - During WB only the ALU drives bus.
//  Arithmetic wrap is performed by the ALU (modulo 2^WIDTH). acc simply captures the bus value.
//  Unknown cmd_mode is impossible; all 8 codes are legal.
// CONFIGURATION
//  ALU_SEQ_ACC_READ_EN (macro):
//   - When defined, adds input acc_rd (1 bit).
//   - acc_rd high in IDLE with cmd_valid low: drive acc onto bus for that single cycle, cmd_ready = 0 that cycle.
//   - If acc_rd and cmd_valid are both high, the command wins and acc_rd is ignored.
//   - When not defined: no acc_rd port, and the sequencer's bus driver is permanently 'z.
// STRUCTURE
//  Package alu_seq_pkg holds:
//   - ALU mode localparams (ALU_ADD..ALU_XOR = 3'b000..3'b111).
//   - State encoding (IDLE, EXEC, WAIT, WB).
//   - Helper function mode_sets_carry(mode).
//  No sub-module; the FSM and datapath are small enough for one module.
// TESTING
//  Bench instantiates the team ALU plus this block on a shared bus.
//  1. Reset, then add with acc = 8'h00, operand 8'h05:
//     -> done at cycle 4; acc = 8'h05; zero = 0; carry = 0; ee and eo each high exactly 1 cycle.
//  2. acc = 8'hFF, add operand 8'h01:
//     -> acc = 8'h00; flag_zero = 1; flag_carry = 1.
//     Follow with or operand 8'h00 -> flag_zero = 1 again, then or 8'h01 -> flag_zero = 0 (zero not sticky).
//  3. acc = 8'h03, sub operand 8'h05:
//     -> acc = 8'hFE; carry = 1. Then inc -> acc = 8'hFF, carry still 1.
//  4. cmd_valid held high for 10 cycles:
//     -> exactly 3 accepts (cycles 0, 4, 8); cmd_ready low during EXEC/WAIT/WB.
//  5. rst asserted during WAIT:
//     -> next cycle acc = ACC_RESET, eo never pulses, done stays 0, bus stays 'z.
//  6. With ALU_SEQ_ACC_READ_EN, acc = 8'hA5, pulse acc_rd in IDLE:
//     -> bus = 8'hA5 that cycle only. Simultaneous cmd_valid -> command accepted, bus not driven.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: ALU mode codes,
// sequencer state encoding and small helpers that classify modes by how
// they affect the carry flag.
package alu_seq_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_ADC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_INC = 3'b011;
  localparam logic [2:0] ALU_DEC = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } seq_state_t;

  // Arithmetic ops whose carry/borrow is published as flag_carry.
  function automatic logic mode_sets_carry(input logic [2:0] mode);
    return (mode == ALU_ADD) || (mode == ALU_ADC) || (mode == ALU_SUB);
  endfunction

  // Logic ops force the carry flag low; inc/dec leave it untouched.
  function automatic logic mode_clears_carry(input logic [2:0] mode);
    return (mode == ALU_AND) || (mode == ALU_OR) || (mode == ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Issuing side of the ALU interface. Owns the accumulator and the B operand
// register, runs one ALU command per IDLE->EXEC->WAIT->WB pass, reads the
// result back off the shared tristate bus and publishes zero/carry flags.
// Optional feature macro: ALU_SEQ_ACC_READ_EN adds acc_rd, which lets the
// accumulator be driven onto the bus for one cycle while idle.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_mode,
  output logic             alu_ee,
  output logic             alu_eo,
  input  logic             alu_carry,
`ifdef ALU_SEQ_ACC_READ_EN
  input  logic             acc_rd,
`endif
  inout  wire  [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] acc,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             done
);

  seq_state_t state;
  seq_state_t next_state;
  logic       accept;

`ifdef ALU_SEQ_ACC_READ_EN
  logic acc_drive;
`endif

  assign alu_a = acc;

`ifdef ALU_SEQ_ACC_READ_EN
  assign bus = acc_drive ? acc : {WIDTH{1'bz}};
`else
  assign bus = {WIDTH{1'bz}};
`endif

  // Next-state, handshake and optional bus-read decode; a pending command
  // always takes priority over an accumulator read.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    cmd_ready  = (state == IDLE);
`ifdef ALU_SEQ_ACC_READ_EN
    acc_drive  = 1'b0;
    if ((state == IDLE) && acc_rd && !cmd_valid) begin
      acc_drive = 1'b1;
      cmd_ready = 1'b0;
    end
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC:    next_state = WAIT;
      WAIT:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset returns to IDLE and abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered ALU controls and datapath: ee/eo are set one edge early so
  // they are high exactly in EXEC and WB, and write-back lands at the WB edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= ACC_RESET;
      alu_b      <= '0;
      alu_mode   <= ALU_ADD;
      alu_ee     <= 1'b0;
      alu_eo     <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      done       <= 1'b0;
    end else begin
      alu_ee <= (next_state == EXEC);
      alu_eo <= (next_state == WB);
      done   <= (state == WB);
      if (accept) begin
        alu_b    <= cmd_operand;
        alu_mode <= cmd_mode;
      end
      if (state == WB) begin
        acc       <= bus;
        flag_zero <= (bus == '0);
        if (mode_sets_carry(alu_mode)) begin
          flag_carry <= alu_carry;
        end else if (mode_clears_carry(alu_mode)) begin
          flag_carry <= 1'b0;
        end
      end
    end
  end

endmodule
